// File: rtl/icache_fill_arbiter_if.sv
// AXI4 read-address and read-data channel bundle between the fill arbiter and the memory interconnect.
// Latency: none, this is wiring only.
// Backpressure: AR uses the valid/ready pair; R has a ready signal, but the arbiter holds it high throughout a fill.
interface icache_fill_arbiter_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_SIZE-1:0]  araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    // The arbiter side issues AR and consumes R.
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    // The memory side accepts AR and produces R.
    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_fill_arbiter.sv
// Round-robin arbiter that shares one AXI4 read channel among NUM_REQ cache-line fill requesters.
// Latency: o_arvalid goes high 1 cycle after a request is sampled, o_gnt 1 cycle after the AR handshake, and beats 1 cycle after R.
// Backpressure: AR stalls on arready; R is never backpressured, because rready stays high in DATA.
module icache_fill_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                              i_aclk,
    input  logic                              i_areset_n,
    input  logic [NUM_REQ-1:0]                i_req,
    input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] i_addr,
    output logic [NUM_REQ-1:0]                o_gnt,
    output logic [NUM_REQ-1:0]                o_rvalid,
    output logic [DATA_WIDTH-1:0]             o_rdata,
    output logic [BEAT_W-1:0]                 o_beat,
    output logic [NUM_REQ-1:0]                o_done,
    output logic                              o_err,
    icache_fill_arbiter_if.master             axi
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OFF_W = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~((ADDR_SIZE'(1) << OFF_W) - ADDR_SIZE'(1));
    localparam logic [7:0]        AR_LEN    = 8'(BURST_LEN - 1);
    localparam logic [2:0]        AR_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [BEAT_W-1:0]    beat_cnt;
    logic                 err_flag;
    logic [ADDR_SIZE-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic [2:0]           ar_size;
    logic [1:0]           ar_burst;

    logic [NUM_REQ-1:0]   req_eligible;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [PTR_W-1:0]     next_ptr;
    logic [ADDR_SIZE-1:0] pick_addr;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick_idx;
    int                   cand;

    // The requester that was just completed is still holding i_req during its o_done cycle, so it is masked out to prevent a duplicate fill.
    assign req_eligible = i_req & ~o_done;
    assign owner_oh     = NUM_REQ'(1) << owner;
    assign next_ptr     = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign pick_addr    = i_addr[pick_idx] & LINE_MASK;

    assign axi.araddr  = ar_addr;
    assign axi.arlen   = ar_len;
    assign axi.arsize  = ar_size;
    assign axi.arburst = ar_burst;
    assign axi.arvalid = (state == S_ADDR);
    assign axi.rready  = (state == S_DATA);

    // Find the first eligible requester at or after rr_ptr. The scan runs from far to near, so the nearest requester is assigned last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(cand);
            end
        end
    end

    // Arbitration FSM, AR field capture, and the registered R steering path.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            err_flag <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            o_gnt    <= '0;
            o_rvalid <= '0;
            o_rdata  <= '0;
            o_beat   <= '0;
            o_done   <= '0;
            o_err    <= 1'b0;
        end else begin
            o_gnt    <= '0;
            o_rvalid <= '0;
            o_rdata  <= '0;
            o_beat   <= '0;
            o_done   <= '0;
            o_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick_idx;
                        ar_addr  <= pick_addr;
                        ar_len   <= AR_LEN;
                        ar_size  <= AR_SIZE;
                        ar_burst <= 2'b01;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi.arready) begin
                        o_gnt    <= owner_oh;
                        beat_cnt <= '0;
                        err_flag <= 1'b0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (axi.rvalid) begin
                        o_rvalid <= owner_oh;
                        o_rdata  <= axi.rdata;
                        o_beat   <= beat_cnt;
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (axi.rlast) begin
                            o_done <= owner_oh;
                            o_err  <= err_flag || (axi.rresp != 2'b00) || (beat_cnt != LAST_BEAT);
                            rr_ptr <= next_ptr;
                            state  <= S_IDLE;
                        end else if ((axi.rresp != 2'b00) || (beat_cnt == LAST_BEAT)) begin
                            // An error response, or a full line of beats with no rlast, marks the fill as bad.
                            err_flag <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fill_arbiter.sv
// Directed bench for icache_fill_arbiter with NUM_REQ=2, a 32-bit bus, and 4-beat lines.
// Latency: inputs are driven 1 time unit after each rising edge, and registered outputs are sampled at the same point.
// Backpressure: the bench's memory model holds arready high except in the AR stall scenario.
module tb_icache_fill_arbiter;
    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0]        o_gnt, o_rvalid, o_done;
    logic [31:0]       o_rdata;
    logic [1:0]        o_beat;
    logic              o_err;

    int tests = 0;
    int fails = 0;

    logic [1:0]  ob_rvalid [8];
    logic [31:0] ob_rdata  [8];
    logic [1:0]  ob_beat   [8];
    logic [1:0]  ob_done   [8];
    logic        ob_err    [8];
    logic [1:0]  gap_rvalid;

    icache_fill_arbiter_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) axi ();

    icache_fill_arbiter #(.NUM_REQ(2), .ADDR_SIZE(32), .DATA_WIDTH(32), .BURST_LEN(4)) dut (
        .i_aclk     (clk),
        .i_areset_n (rst_n),
        .i_req      (req),
        .i_addr     (addr),
        .o_gnt      (o_gnt),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .o_beat     (o_beat),
        .o_done     (o_done),
        .o_err      (o_err),
        .axi        (axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [1:0] g, output int waited);
        g = 2'b00;
        waited = 0;
        while (g == 2'b00 && waited < 20) begin
            tick();
            waited++;
            g = o_gnt;
        end
    endtask

    task automatic run_beats(input int n, input int last_idx, input int err_idx, input bit gap, input logic [31:0] base);
        gap_rvalid = 2'b00;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                tick();
                gap_rvalid = gap_rvalid | o_rvalid;
            end
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(i);
            axi.rresp  = (i == err_idx) ? 2'b10 : 2'b00;
            axi.rlast  = (i == last_idx);
            tick();
            ob_rvalid[i] = o_rvalid;
            ob_rdata[i]  = o_rdata;
            ob_beat[i]   = o_beat;
            ob_done[i]   = o_done;
            ob_err[i]    = o_err;
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        axi.rdata  = 32'h0;
    endtask

    task automatic test_reset();
        logic [46:0] ar_bus;
        logic [40:0] req_bus;
        ar_bus  = {axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.rready};
        req_bus = {o_gnt, o_rvalid, o_done, o_err, o_beat, o_rdata};
        tests++; if (ar_bus !== 47'h0) begin fails++; $display("FAIL reset_axi: got %h want 0", ar_bus); end
        tests++; if (req_bus !== 41'h0) begin fails++; $display("FAIL reset_req: got %h want 0", req_bus); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tests++; if (axi.arvalid !== 1'b0 || o_gnt !== 2'b00) begin fails++; $display("FAIL reset_idle: arvalid %b gnt %b want 0 0", axi.arvalid, o_gnt); end
    endtask

    task automatic test_single_fill();
        logic [1:0] g; int w;
        req = 2'b01; addr[0] = 32'h0000_1234;
        tick();
        tests++; if (axi.arvalid !== 1'b1) begin fails++; $display("FAIL single_arvalid: got %b want 1", axi.arvalid); end
        tests++; if (axi.araddr !== 32'h0000_1230) begin fails++; $display("FAIL single_araddr: got %h want 00001230", axi.araddr); end
        tests++; if ({axi.arlen, axi.arsize, axi.arburst} !== {8'd3, 3'd2, 2'd1}) begin fails++; $display("FAIL single_arfields: got len %0d size %0d burst %0d want 3 2 1", axi.arlen, axi.arsize, axi.arburst); end
        wait_gnt(g, w);
        req = 2'b00;
        tests++; if (g !== 2'b01 || w != 1) begin fails++; $display("FAIL single_gnt: got %b after %0d want 01 after 1", g, w); end
        tests++; if (axi.rready !== 1'b1) begin fails++; $display("FAIL single_rready: got %b want 1", axi.rready); end
        run_beats(4, 3, -1, 1'b0, 32'hD000_0000);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ob_rvalid[i] !== 2'b01 || ob_rdata[i] !== 32'hD000_0000 + 32'(i) || ob_beat[i] !== 2'(i) || ob_done[i] !== ((i == 3) ? 2'b01 : 2'b00)) begin
                fails++; $display("FAIL single_beat%0d: got v %b d %h b %0d done %b want 01 %h %0d", i, ob_rvalid[i], ob_rdata[i], ob_beat[i], ob_done[i], 32'hD000_0000 + 32'(i), i);
            end
        end
        tests++; if (ob_err[3] !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", ob_err[3]); end
        tests++; if (axi.rready !== 1'b0) begin fails++; $display("FAIL single_idle_rready: got %b want 0", axi.rready); end
        tick();
        tests++; if (o_rvalid !== 2'b00 || o_done !== 2'b00) begin fails++; $display("FAIL single_quiet: got v %b done %b want 00 00", o_rvalid, o_done); end
    endtask

    task automatic test_ar_stall();
        logic [1:0] g; int gcnt;
        gcnt = 0;
        axi.arready = 1'b0;
        req = 2'b10; addr[1] = 32'h0000_2008;
        tick();
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} !== {1'b1, 32'h0000_2000, 8'd3, 3'd2, 2'd1}) begin
                fails++; $display("FAIL stall_hold%0d: got v %b a %h len %0d", c, axi.arvalid, axi.araddr, axi.arlen);
            end
            if (o_gnt != 2'b00) gcnt++;
            tick();
        end
        axi.arready = 1'b1;
        tick();
        g = o_gnt;
        if (o_gnt != 2'b00) gcnt++;
        req = 2'b00;
        tests++; if (g !== 2'b10) begin fails++; $display("FAIL stall_gnt: got %b want 10", g); end
        tick();
        if (o_gnt != 2'b00) gcnt++;
        tests++; if (gcnt != 1) begin fails++; $display("FAIL stall_gnt_count: got %0d want 1", gcnt); end
        tests++; if (axi.arvalid !== 1'b0) begin fails++; $display("FAIL stall_arvalid_drop: got %b want 0", axi.arvalid); end
        run_beats(4, 3, -1, 1'b0, 32'h5000_0000);
        tests++; if (ob_done[3] !== 2'b10 || ob_err[3] !== 1'b0) begin fails++; $display("FAIL stall_done: got %b err %b want 10 0", ob_done[3], ob_err[3]); end
    endtask

    task automatic test_contention(input logic [1:0] first, input string name);
        logic [1:0] g; int w;
        logic [1:0] second;
        second = ~first;
        req = 2'b11; addr[0] = 32'h0000_0104; addr[1] = 32'h0000_204C;
        wait_gnt(g, w);
        req = req & ~g;
        tests++; if (g !== first) begin fails++; $display("FAIL %s_first: got %b want %b", name, g, first); end
        tests++; if (axi.araddr !== ((first == 2'b01) ? 32'h0000_0100 : 32'h0000_2040)) begin fails++; $display("FAIL %s_addr1: got %h", name, axi.araddr); end
        run_beats(4, 3, -1, 1'b0, 32'h1000_0000);
        tests++; if (ob_done[3] !== first) begin fails++; $display("FAIL %s_done1: got %b want %b", name, ob_done[3], first); end
        wait_gnt(g, w);
        req = 2'b00;
        tests++; if (g !== second) begin fails++; $display("FAIL %s_second: got %b want %b", name, g, second); end
        run_beats(4, 3, -1, 1'b0, 32'h2000_0000);
        tests++; if (ob_rvalid[0] !== second || ob_done[3] !== second) begin fails++; $display("FAIL %s_done2: got v %b done %b want %b", name, ob_rvalid[0], ob_done[3], second); end
    endtask

    task automatic test_err_rresp();
        logic [1:0] g; int w;
        req = 2'b01; addr[0] = 32'h0000_0040;
        wait_gnt(g, w);
        req = 2'b00;
        run_beats(4, 3, 2, 1'b0, 32'h3000_0000);
        tests++; if (ob_done[3] !== 2'b01 || ob_err[3] !== 1'b1) begin fails++; $display("FAIL err_rresp: got done %b err %b want 01 1", ob_done[3], ob_err[3]); end
        tests++; if (ob_err[2] !== 1'b0) begin fails++; $display("FAIL err_rresp_early: got %b want 0", ob_err[2]); end
    endtask

    task automatic test_err_early_last();
        logic [1:0] g; int w;
        req = 2'b10; addr[1] = 32'h0000_0080;
        wait_gnt(g, w);
        req = 2'b00;
        run_beats(2, 1, -1, 1'b0, 32'h4000_0000);
        tests++; if (ob_done[0] !== 2'b00 || ob_done[1] !== 2'b10 || ob_err[1] !== 1'b1) begin fails++; $display("FAIL early_last: got done %b %b err %b want 00 10 1", ob_done[0], ob_done[1], ob_err[1]); end
        tests++; if (axi.rready !== 1'b0) begin fails++; $display("FAIL early_last_idle: got rready %b want 0", axi.rready); end
    endtask

    task automatic test_r_gaps();
        logic [1:0] g; int w;
        req = 2'b01; addr[0] = 32'h0000_00C0;
        wait_gnt(g, w);
        req = 2'b00;
        run_beats(4, 3, -1, 1'b1, 32'h6000_0000);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ob_rvalid[i] !== 2'b01 || ob_beat[i] !== 2'(i) || ob_rdata[i] !== 32'h6000_0000 + 32'(i)) begin
                fails++; $display("FAIL gaps_beat%0d: got v %b b %0d d %h", i, ob_rvalid[i], ob_beat[i], ob_rdata[i]);
            end
        end
        tests++; if (gap_rvalid !== 2'b00) begin fails++; $display("FAIL gaps_idle_rvalid: got %b want 00", gap_rvalid); end
        tests++; if (ob_done[3] !== 2'b01 || ob_err[3] !== 1'b0) begin fails++; $display("FAIL gaps_done: got %b err %b want 01 0", ob_done[3], ob_err[3]); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g; int w;
        logic [40:0] req_bus;
        req = 2'b10; addr[1] = 32'h0000_0100;
        wait_gnt(g, w);
        req = 2'b00;
        run_beats(2, -1, -1, 1'b0, 32'h7000_0000);
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h7000_0002;
        rst_n = 1'b0;
        #1;
        req_bus = {o_gnt, o_rvalid, o_done, o_err, o_beat, o_rdata};
        tests++; if (req_bus !== 41'h0) begin fails++; $display("FAIL midrst_outs: got %h want 0", req_bus); end
        tests++; if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0) begin fails++; $display("FAIL midrst_axi: rready %b arvalid %b want 0 0", axi.rready, axi.arvalid); end
        tick();
        tests++; if (o_done !== 2'b00) begin fails++; $display("FAIL midrst_done: got %b want 00", o_done); end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = 32'h0;
        rst_n = 1'b1;
        tick();
        req = 2'b11; addr[0] = 32'h0000_0200; addr[1] = 32'h0000_0300;
        wait_gnt(g, w);
        req = 2'b00;
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL midrst_fresh_gnt: got %b want 01", g); end
        run_beats(4, 3, -1, 1'b0, 32'h8000_0000);
        tests++; if (ob_beat[0] !== 2'd0 || ob_done[3] !== 2'b01 || ob_err[3] !== 1'b0) begin fails++; $display("FAIL midrst_fresh_burst: beat0 %0d done %b err %b", ob_beat[0], ob_done[3], ob_err[3]); end
    endtask

    initial begin
        req = 2'b00;
        addr = '0;
        axi.arready = 1'b1;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        test_single_fill();
        test_ar_stall();
        test_contention(2'b01, "cont1");
        test_err_rresp();
        test_contention(2'b10, "cont2");
        test_err_early_last();
        test_r_gaps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/icache_fill_arbiter.md
# icache_fill_arbiter

Shares one AXI4 read channel between `NUM_REQ` cache-line fill requesters (instruction cache controllers per core, plus any later data cache) in the multicore design. Grants the channel with round-robin fairness, issues one INCR burst per line fill, and steers the returned beats to the granted requester with a beat index. Sits between the cache controllers and the system memory interconnect.

## Interface
- `NUM_REQ`, 2, number of fill requesters (≥1).
- `ADDR_SIZE`, 32, address width.
- `DATA_WIDTH`, 32, AXI read data width; one instruction word per beat.
- `BURST_LEN`, 4, beats per line fill (WORDS_PER_LINE); power of two, ≤256.

Ports:
- `i_aclk` in 1: system clock; all logic on its rising edge.
- `i_areset_n` in 1: asynchronous, active-low reset.
- `i_req` in NUM_REQ: per-requester fill request, level.
- `i_addr` in NUM_REQ×ADDR_SIZE: per-requester miss address.
- `o_gnt` out NUM_REQ: one-hot, one-cycle pulse when the requester's AR handshake completes.
- `o_rvalid` out NUM_REQ: one-hot, beat valid for owner.
- `o_rdata` out DATA_WIDTH: beat data, shared by all requesters.
- `o_beat` out clog2(BURST_LEN): word index of the current beat.
- `o_done` out NUM_REQ: one-cycle pulse with the owner's last beat.
- `o_err` out 1: valid with `o_done`; any beat had RRESP≠OKAY or the beat count was wrong.
- `o_araddr` out ADDR_SIZE, `o_arlen` out 8, `o_arsize` out 3, `o_arburst` out 2, `o_arvalid` out 1, `i_arready` in 1: AXI AR channel.
- `i_rdata` in DATA_WIDTH, `i_rresp` in 2, `i_rlast` in 1, `i_rvalid` in 1, `o_rready` out 1: AXI R channel.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any `i_req`, pick the first requesting index at or after `rr_ptr` (wrapping modulo NUM_REQ). Latch the owner and `i_addr[owner]`, with the low clog2(BURST_LEN·DATA_WIDTH/8) bits forced to 0 (line aligned). Go to ADDR.
- ADDR: `o_arvalid`=1, with `o_arlen`=BURST_LEN−1, `o_arsize`=clog2(DATA_WIDTH/8), `o_arburst`=2'b01. AR fields stay stable until `i_arready`. On handshake: pulse `o_gnt[owner]`, clear the beat counter and error flag, go to DATA.
- DATA: `o_rready`=1 constantly. Each `i_rvalid` beat drives `o_rvalid[owner]`=1, `o_rdata`=`i_rdata` and `o_beat`=counter, then increments the counter. `i_rresp`≠0 sets the error flag.
- On the `i_rlast` beat: pulse `o_done[owner]`, drive `o_err` = flag OR (rresp≠0 this beat) OR (counter≠BURST_LEN−1). Set `rr_ptr`=owner+1 (wrap), go to IDLE.
- A beat count reaching BURST_LEN without `i_rlast` also sets the error flag. Extra beats are still forwarded, and `o_beat` wraps.
- Outputs other than AR fields are 0 whenever not asserted.
- Requester rules:
  - Hold `i_req` and `i_addr` stable until its `o_gnt`.
  - Drop `i_req` in the cycle after `o_done` unless it has a new miss.
  - Accept every beat; there is no backpressure.
- `i_req` changes after grant are ignored; the burst always completes.

## Timing
- Reset (async assert, synchronous-effect release): state IDLE, `rr_ptr`=0. All outputs 0: `o_arvalid`, `o_araddr`, `o_arlen`, `o_arsize`, `o_arburst`, `o_rready`, `o_gnt`, `o_rvalid`, `o_rdata`, `o_beat`, `o_done`, `o_err`.
- Reset mid-burst: abort immediately, no `o_done`. Downstream responsibility covers any outstanding AXI beats.
- Request sampled in cycle T → `o_arvalid` registered high in T+1.
- `o_gnt` is registered, high the cycle after the AR handshake.
- R path is registered: `o_rvalid`/`o_rdata`/`o_beat` appear one cycle after the `i_rvalid` beat, and `o_done`/`o_err` align with the last forwarded beat.
- After `o_done`, the FSM is in IDLE the same cycle. Next `o_arvalid` is no earlier than 2 cycles after the last beat is accepted.
- Simultaneous requests in IDLE: round-robin from `rr_ptr`. No requester waits more than NUM_REQ−1 other fills.
- `o_arvalid` never drops before `i_arready`.
- `o_rready` is 0 outside DATA.

## Test plan
- Single fill: `i_req[0]`, `i_addr`=0x0000_1234, BURST_LEN=4.
  - AR: `o_araddr`=0x0000_1230, `o_arlen`=3, `o_arsize`=2, `o_arburst`=1.
  - Four beats D0..D3 give `o_rvalid[0]` with `o_beat` 0..3.
  - `o_done[0]` with the 4th beat, `o_err`=0.
- Contention: `i_req`=2'b11 with `rr_ptr`=0.
  - Req0 served first, then req1. A second contention round serves req1 before req0.
- AR stall: `i_arready` low for 5 cycles.
  - `o_arvalid` and the AR fields are held constant.
  - `o_gnt` pulses exactly once, after the handshake.
- Errors:
  - Beat 2 with `i_rresp`=2'b10 → `o_err`=1 at `o_done`.
  - `i_rlast` on beat 2 of 4 → early done, `o_err`=1.
- R gaps: `i_rvalid` deasserted between beats → beats forwarded in order, `o_beat` contiguous 0..3.
- Reset mid-DATA after 2 beats → all outputs 0 within the same cycle, no `o_done`. A request after release starts a fresh burst from req0.
